stopwatch_ctrl: RTL and testbench

Control sequencer for the six-digit stopwatch display datapath. Debounces the start, pause, continue and lap buttons and runs the stopwatch state machine. Drives the cascaded BCD digit counters with a single-cycle 100 Hz count-enable tick, a synchronous clear pulse and a display-hold flag. All outputs are synchronous to `clk`, which replaces the ripple/derived clocks previously used to step the digit chain.

---
 rtl/stopwatch_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control sequencer for the six-digit stopwatch display datapath.
//   Each button goes through a two-flop synchronizer and a debouncer that
//   emits a one-cycle press pulse. Presses arriving in the same cycle are
//   resolved by priority start > pause > conti > lap. The winning press
//   drives the stopwatch state machine. A free-running divider produces the
//   100 Hz count-enable tick for the digit chain. Everything runs on clk, and
//   every output comes straight from a flop.
//
// Parameters
//   TICK_DIV   clk cycles per count tick (>= 2)
//   DB_CYCLES  stable synchronized cycles needed to accept a button level (>= 1)
//
// Ports
//   clk        system clock
//   rst_all    asynchronous, active-high reset
//   btn_start  raw start button (active-high, asynchronous to clk)
//   btn_pause  raw pause button
//   btn_conti  raw continue button
//   btn_lap    raw lap button (ignored unless STOPWATCH_LAP_EN is defined)
//   tick       one-cycle count enable for the least-significant digit
//   cnt_clr    one-cycle synchronous clear for all digit counters
//   running    high in RUN or LAP
//   disp_hold  high in LAP (display latches frozen)
//   state      FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11
//
// Build option
//   STOPWATCH_LAP_EN  when defined, builds the lap debouncer and the LAP
//                     state. When undefined, btn_lap is ignored, disp_hold
//                     is tied 0 and state never reads 11.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 1000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_all,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_conti,
    input  logic       btn_lap,
    output logic       tick,
    output logic       cnt_clr,
    output logic       running,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Bit order of the button vectors: 0 start, 1 pause, 2 conti, 3 lap
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] press;

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {btn_lap, btn_conti, btn_pause, btn_start};
`else
    logic unused_lap;
    assign btn_raw    = {btn_conti, btn_pause, btn_start};
    assign unused_lap = btn_lap;
`endif

    // Debouncers. The counter measures how long the synchronized level has
    // differed from the accepted level. Any return to the accepted level
    // restarts the count, so only an uninterrupted run of DB_CYCLES cycles
    // flips the accepted level. Only the rising edge of the accepted level
    // becomes a press pulse.
    for (genvar i = 0; i < NB; i++) begin : g_db
        logic [1:0]    sync;
        logic          level;
        logic          level_d;
        logic          press_q;
        logic [DW-1:0] db_cnt;

        always_ff @(posedge clk or posedge rst_all) begin
            if (rst_all) begin
                sync    <= 2'b00;
                level   <= 1'b0;
                level_d <= 1'b0;
                press_q <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync    <= {sync[0], btn_raw[i]};
                level_d <= level;
                press_q <= level & ~level_d;
                if (sync[1] == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                    level  <= ~level;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign press[i] = press_q;
    end

    // The highest-priority press wins. The others in the same cycle are
    // dropped, even when the winner has no effect in the current state.
    logic go_start;
    logic go_pause;
    logic go_conti;
`ifdef STOPWATCH_LAP_EN
    logic go_lap;
`endif

    always_comb begin
        go_start = press[0];
        go_pause = press[1] & ~press[0];
        go_conti = press[2] & ~press[1] & ~press[0];
`ifdef STOPWATCH_LAP_EN
        go_lap   = press[3] & ~press[2] & ~press[1] & ~press[0];
`endif
    end

    state_t st_q;
    state_t st_d;
    logic   clr_d;
    logic [TW-1:0] div_q;

    // Next state. Start is a restart from any state.
    always_comb begin
        st_d  = st_q;
        clr_d = 1'b0;
        if (go_start) begin
            st_d  = ST_RUN;
            clr_d = 1'b1;
        end else begin
            case (st_q)
                ST_RUN: begin
                    if (go_pause) st_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                    if (go_lap)   st_d = ST_LAP;
`endif
                end
                ST_PAUSE: begin
                    if (go_conti) st_d = ST_RUN;
                end
`ifdef STOPWATCH_LAP_EN
                ST_LAP: begin
                    if (go_pause) st_d = ST_PAUSE;
                    if (go_lap)   st_d = ST_RUN;
                end
`endif
                default: ;
            endcase
        end
    end

    // The state register and the registered outputs. The divider steps on
    // edges where the current state is RUN or LAP. In IDLE/PAUSE it holds
    // its value, so a resume continues from the same fractional phase. A
    // restart clears the divider and masks any tick due on that same edge.
    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            st_q    <= ST_IDLE;
            cnt_clr <= 1'b0;
            running <= 1'b0;
            tick    <= 1'b0;
            div_q   <= '0;
        end else begin
            st_q    <= st_d;
            cnt_clr <= clr_d;
            running <= (st_d == ST_RUN) || (st_d == ST_LAP);
            if (clr_d) begin
                div_q <= '0;
                tick  <= 1'b0;
            end else if ((st_q == ST_RUN) || (st_q == ST_LAP)) begin
                if (div_q == TW'(TICK_DIV - 1)) begin
                    div_q <= '0;
                    tick  <= 1'b1;
                end else begin
                    div_q <= div_q + 1'b1;
                    tick  <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) disp_hold <= 1'b0;
        else         disp_hold <= (st_d == ST_LAP);
    end
`else
    assign disp_hold = 1'b0;
`endif

    assign state = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with TICK_DIV=10 and DB_CYCLES=4.
//   Button stimulus is driven on the falling edge. The bench keeps its own
//   expected state, and its own divider phase counted in run cycles. Each
//   cycle it pushes the tick/cnt_clr events it expects one cycle ahead into
//   exp_q. On the next falling edge it pops those events and compares them
//   with what the DUT shows.
//   The lap expectations follow STOPWATCH_LAP_EN. Without it, lap presses
//   are expected to change nothing.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int HOLD      = 12;
    localparam int LATENCY   = 8;   // drive edge to visible state/cnt_clr

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;
`ifdef STOPWATCH_LAP_EN
    localparam logic [1:0] S_LAPX  = S_LAP;
`else
    localparam logic [1:0] S_LAPX  = S_RUN;
`endif

    logic       clk;
    logic       rst_all;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_conti;
    logic       btn_lap;
    logic       tick;
    logic       cnt_clr;
    logic       running;
    logic       disp_hold;
    logic [1:0] state;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_all   (rst_all),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .btn_conti (btn_conti),
        .btn_lap   (btn_lap),
        .tick      (tick),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .disp_hold (disp_hold),
        .state     (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    // exp_q entry: {is_clr, cycle[19:0]}
    logic [20:0] exp_q[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [1:0]  st, st_n;       // expected state this cycle / next cycle
    int          ph, ph_n;       // expected divider phase this cycle / next
    bit          pend_v;
    int          pend_cyc;
    logic [1:0]  pend_st;
    logic        pend_clr;

    typedef struct {
        logic [3:0] btn;         // {lap, conti, pause, start}
        logic [1:0] exp_state;
        logic       exp_clr;
        int         gap;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic check_state();
        chk("state", int'(state), int'(st));
        chk("running", int'(running), int'((st == S_RUN) || (st == S_LAP)));
        chk("disp_hold", int'(disp_hold), int'(st == S_LAP));
    endtask

    // Compare this cycle's DUT events against the front of the queue.
    task automatic check_events();
        logic [20:0] f;
        bit          has_f;
        has_f = (exp_q.size() > 0) && (exp_q[0][19:0] == 20'(cyc));
        if (tick && cnt_clr) chk("tick_clr_overlap", 1, 0);
        if (tick || cnt_clr) begin
            if (has_f) begin
                f = exp_q.pop_front();
                chk(f[20] ? "clr_event" : "tick_event", int'({tick, cnt_clr}), f[20] ? 1 : 2);
            end else begin
                chk("unexpected_event", int'({tick, cnt_clr}), 0);
            end
        end else if (has_f) begin
            f = exp_q.pop_front();
            chk(f[20] ? "missing_clr" : "missing_tick", 0, f[20] ? 1 : 2);
        end
    endtask

    // Expected behaviour on the next edge: a scheduled state change and
    // clear, otherwise one run cycle added to the phase and a tick every
    // TICK_DIV run cycles.
    task automatic model_next();
        bit hit;
        hit  = pend_v && (pend_cyc == cyc + 1);
        st_n = hit ? pend_st : st;
        if (hit) pend_v = 1'b0;
        if (hit && pend_clr) begin
            ph_n = 0;
            exp_q.push_back({1'b1, 20'(cyc + 1)});
        end else if ((st == S_RUN) || (st == S_LAP)) begin
            if (ph == TICK_DIV - 1) begin
                ph_n = 0;
                exp_q.push_back({1'b0, 20'(cyc + 1)});
            end else begin
                ph_n = ph + 1;
            end
        end else begin
            ph_n = ph;
        end
    endtask

    task automatic tick_cycle();
        @(negedge clk);
        cyc++;
        st = st_n;
        ph = ph_n;
        check_events();
        model_next();
    endtask

    // Drive a button pattern for HOLD cycles. The expected outcome is
    // scheduled LATENCY cycles after the drive edge and the state outputs
    // are checked once it has settled.
    task automatic press(input logic [3:0] btn, input logic [1:0] exp_state,
                         input logic exp_clr);
        {btn_lap, btn_conti, btn_pause, btn_start} = btn;
        if (exp_clr || (exp_state != st)) begin
            pend_v   = 1'b1;
            pend_cyc = cyc + LATENCY;
            pend_st  = exp_state;
            pend_clr = exp_clr;
        end
        for (int i = 1; i <= HOLD; i++) begin
            tick_cycle();
            if (i == LATENCY + 2) check_state();
        end
        {btn_lap, btn_conti, btn_pause, btn_start} = 4'b0000;
    endtask

    initial begin
        vecs[0]  = '{4'b0100, S_IDLE,  1'b0, 10};  // conti in IDLE ignored
        vecs[1]  = '{4'b0010, S_IDLE,  1'b0, 10};  // pause in IDLE ignored
        vecs[2]  = '{4'b1000, S_IDLE,  1'b0, 10};  // lap in IDLE ignored
        vecs[3]  = '{4'b0001, S_RUN,   1'b1, 25};  // start
        vecs[4]  = '{4'b0100, S_RUN,   1'b0, 13};  // conti in RUN ignored
        vecs[5]  = '{4'b0010, S_PAUSE, 1'b0, 100}; // pause, long wait
        vecs[6]  = '{4'b0010, S_PAUSE, 1'b0, 10};  // pause in PAUSE ignored
        vecs[7]  = '{4'b1000, S_PAUSE, 1'b0, 10};  // lap in PAUSE ignored
        vecs[8]  = '{4'b0100, S_RUN,   1'b0, 17};  // conti resumes phase
        vecs[9]  = '{4'b1000, S_LAPX,  1'b0, 20};  // lap
        vecs[10] = '{4'b0100, S_LAPX,  1'b0, 10};  // conti in LAP ignored
        vecs[11] = '{4'b1000, S_RUN,   1'b0, 15};  // lap again releases hold
        vecs[12] = '{4'b1000, S_LAPX,  1'b0, 10};  // lap
        vecs[13] = '{4'b0010, S_PAUSE, 1'b0, 30};  // pause from LAP
        vecs[14] = '{4'b0100, S_RUN,   1'b0, 10};  // conti
        vecs[15] = '{4'b0011, S_RUN,   1'b1, 23};  // start+pause: restart
        vecs[16] = '{4'b0010, S_PAUSE, 1'b0, 10};  // pause
        vecs[17] = '{4'b0001, S_RUN,   1'b1, 10};  // start from PAUSE

        // ---------------- reset ----------------
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        st        = S_IDLE;
        st_n      = S_IDLE;
        ph        = 0;
        ph_n      = 0;
        pend_v    = 1'b0;
        pend_cyc  = 0;
        pend_st   = S_IDLE;
        pend_clr  = 1'b0;
        rst_all   = 1'b1;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        btn_conti = 1'b0;
        btn_lap   = 1'b0;
        repeat (3) tick_cycle();
        check_state();
        rst_all = 1'b0;
        repeat (50) tick_cycle();
        check_state();

        // ---------------- table-driven presses ----------------
        for (int v = 0; v < 18; v++) begin
            press(vecs[v].btn, vecs[v].exp_state, vecs[v].exp_clr);
            repeat (vecs[v].gap) tick_cycle();
        end

        // ---------------- bouncing start (restart while RUN) ----------------
        for (int k = 0; k < 20; k++) begin
            btn_start = ((k / 2) % 2) == 0;
            tick_cycle();
        end
        press(4'b0001, S_RUN, 1'b1);
        for (int k = 0; k < 12; k++) begin
            btn_start = ((k / 2) % 2) == 1;
            tick_cycle();
        end
        btn_start = 1'b0;
        repeat (20) tick_cycle();

        // ---------------- reset in LAP with divider at 7 ----------------
        press(4'b1000, S_LAPX, 1'b0);
        for (int i = 0; i < 30 && ph != 7; i++) tick_cycle();
        chk("reset_setup_phase", ph, 7);
        rst_all   = 1'b1;
        btn_start = 1'b1;
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_disp_hold", int'(disp_hold), 0);
        chk("rst_state", int'(state), int'(S_IDLE));
        st     = S_IDLE;
        st_n   = S_IDLE;
        ph     = 0;
        ph_n   = 0;
        pend_v = 1'b0;
        exp_q.delete();
        repeat (3) tick_cycle();
        check_state();

        // Start held through reset release: one press after a full debounce.
        rst_all = 1'b0;
        press(4'b0001, S_RUN, 1'b1);
        repeat (40) tick_cycle();

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
